arb_mux_n: RTL and testbench



---
 rtl/arb_mux_n.sv | 124 ++++++++++++
 tb/tb_arb_mux_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_n.sv
// N-way registered selector with a one-entry valid/ready output stage.
// Direct mode picks the channel named by i_sel; round-robin mode rotates among valid requesters.
module arb_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 7,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [NUM_IN-1:0]       i_valid,
    output logic [NUM_IN-1:0]       o_ready,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_rr_en,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [SEL_W-1:0]        o_ch,
    output logic                    o_sel_oor
);

    localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              oor_q, oor_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              can_load;
    logic              sel_oor;
    logic [SEL_W-1:0]  ch_dir;
    logic              rr_hi_found, rr_lo_found;
    logic [SEL_W-1:0]  rr_hi_idx, rr_lo_idx, rr_grant;
    logic [SEL_W-1:0]  sel_ch;
    logic              sel_en;
    logic [NUM_IN-1:0] sel_oh;
    logic [NUM_IN-1:0] ready_c;
    logic              load;
    logic [WIDTH-1:0]  data_mux;

    assign can_load = !valid_q || i_ready;
    assign sel_oor  = ({1'b0, i_sel} >= NUM_IN_L);
    assign ch_dir   = sel_oor ? '0 : i_sel;

    // Requesters above ptr win first; otherwise fall back to the lowest valid index (wrap).
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_found = 1'b0;
        rr_lo_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (i_valid[k]) begin
                rr_lo_found = 1'b1;
                rr_lo_idx   = SEL_W'(k);
                if (SEL_W'(k) > ptr_q) begin
                    rr_hi_found = 1'b1;
                    rr_hi_idx   = SEL_W'(k);
                end
            end
        end
    end

    assign rr_grant = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    assign sel_ch   = i_rr_en ? rr_grant : ch_dir;
    assign sel_en   = i_rr_en ? rr_lo_found : 1'b1;

    always_comb begin
        sel_oh   = '0;
        data_mux = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_en && (SEL_W'(k) == sel_ch)) begin
                sel_oh[k] = 1'b1;
                data_mux  = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign ready_c = (!rst && can_load) ? sel_oh : '0;
    assign load    = |(ready_c & i_valid);
    assign o_ready = ready_c;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        oor_d   = oor_q;
        ptr_d   = ptr_q;
        if (load) begin
            data_d  = data_mux;
            valid_d = 1'b1;
            ch_d    = sel_ch;
            oor_d   = !i_rr_en && sel_oor;
            if (i_rr_en) begin
                ptr_d = rr_grant;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            oor_q   <= 1'b0;
            ptr_q   <= PTR_RST;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            oor_q   <= oor_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_ch      = ch_q;
    assign o_sel_oor = oor_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios followed by random traffic,
// compared every cycle against a behavioural model of the selector.
module tb_arb_mux_n;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 7;
    localparam int SEL_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] i_data;
    logic [NUM_IN-1:0]       i_valid;
    logic [NUM_IN-1:0]       o_ready;
    logic [SEL_W-1:0]        i_sel;
    logic                    i_rr_en;
    logic [WIDTH-1:0]        o_data;
    logic                    o_valid;
    logic                    i_ready;
    logic [SEL_W-1:0]        o_ch;
    logic                    o_sel_oor;

    int errors = 0;
    int checks = 0;

    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_ch;
    logic             m_oor;
    int               m_ptr;

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_sel(i_sel), .i_rr_en(i_rr_en), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_ch(o_ch), .o_sel_oor(o_sel_oor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected o_ready and the channel that would be served this cycle (-1 if none).
    function automatic logic [NUM_IN-1:0] model_ready(output int ch);
        logic can;
        ch = -1;
        if (rst) return '0;
        can = !m_valid || i_ready;
        if (!i_rr_en) begin
            ch = (int'(i_sel) < NUM_IN) ? int'(i_sel) : 0;
        end else begin
            for (int off = 1; off <= NUM_IN; off++) begin
                int k;
                k = (m_ptr + off) % NUM_IN;
                if (i_valid[k] && ch < 0) ch = k;
            end
        end
        if (!can || ch < 0) return '0;
        return NUM_IN'(1) << ch;
    endfunction

    task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
        i_data[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic cycle();
        logic [NUM_IN-1:0] er;
        int               ch;
        logic             ld;
        logic             n_valid, n_oor;
        logic [WIDTH-1:0] n_data;
        int               n_ch, n_ptr;
        @(negedge clk);
        er = model_ready(ch);
        check("o_ready",   32'(o_ready),   32'(er));
        check("o_valid",   32'(o_valid),   32'(m_valid));
        check("o_data",    o_data,         m_data);
        check("o_ch",      32'(o_ch),      32'(m_ch));
        check("o_sel_oor", 32'(o_sel_oor), 32'(m_oor));
        ld = |(er & i_valid);
        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_oor = m_oor; n_ptr = m_ptr;
        if (rst) begin
            n_valid = 1'b0; n_data = '0; n_ch = 0; n_oor = 1'b0; n_ptr = NUM_IN - 1;
        end else if (ld) begin
            n_valid = 1'b1;
            n_data  = i_data[ch*WIDTH +: WIDTH];
            n_ch    = ch;
            n_oor   = !i_rr_en && (int'(i_sel) >= NUM_IN);
            if (i_rr_en) n_ptr = ch;
        end else if (i_ready) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_oor = n_oor; m_ptr = n_ptr;
    endtask

    int rr_exp [6] = '{0, 2, 5, 0, 2, 5};

    initial begin
        rst = 1'b1; i_data = '0; i_valid = '0; i_sel = '0; i_rr_en = 1'b0; i_ready = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_oor = 1'b0; m_ptr = NUM_IN - 1;
        cycle();
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_data", o_data, 32'd0);

        // Direct pass-through
        rst = 1'b0; i_sel = 4'd3; set_ch(3, 32'h0000_00A5); i_valid = 7'b0001000;
        #1;
        check("direct_ready", 32'(o_ready), 32'b0001000);
        cycle();
        check("direct_data", o_data, 32'h0000_00A5);
        check("direct_ch", 32'(o_ch), 32'd3);
        check("direct_oor", 32'(o_sel_oor), 32'd0);

        // Out-of-range select falls back to channel 0
        i_sel = 4'd9; set_ch(0, 32'h1234_5678); i_valid = 7'b0000001;
        #1;
        check("oor_ready", 32'(o_ready), 32'd1);
        cycle();
        check("oor_data", o_data, 32'h1234_5678);
        check("oor_ch", 32'(o_ch), 32'd0);
        check("oor_flag", 32'(o_sel_oor), 32'd1);

        // Backpressure
        i_sel = 4'd3; set_ch(3, 32'h11); i_valid = 7'b0001000;
        cycle();
        set_ch(3, 32'h22); i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(o_ready), 32'd0);
            cycle();
            check("bp_data", o_data, 32'h11);
            check("bp_valid", 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        cycle();
        check("bp_release_data", o_data, 32'h22);
        check("bp_release_valid", 32'(o_valid), 32'd1);
        i_valid = '0;
        cycle();
        check("drain_valid", 32'(o_valid), 32'd0);

        // Round-robin fairness from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0; i_rr_en = 1'b1;
        for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'hC0 + 32'(k));
        i_valid = 7'b0100101;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_seq_ch", 32'(o_ch), 32'(rr_exp[i]));
        end

        // Wrap and mode switch
        i_valid = 7'b1000000;
        cycle();
        check("wrap_ch6", 32'(o_ch), 32'd6);
        i_rr_en = 1'b0; i_sel = 4'd1; i_valid = 7'b0000010;
        cycle();
        cycle();
        check("switch_direct_ch", 32'(o_ch), 32'd1);
        i_rr_en = 1'b1; i_valid = 7'b1000001;
        cycle();
        check("wrap_to_ch0", 32'(o_ch), 32'd0);

        // Reset while a word is held
        i_rr_en = 1'b0; i_sel = 4'd2; set_ch(2, 32'hDEAD_BEEF); i_valid = 7'b0000100;
        cycle();
        check("pre_reset_data", o_data, 32'hDEAD_BEEF);
        i_ready = 1'b0; rst = 1'b1;
        cycle();
        check("mid_reset_valid", 32'(o_valid), 32'd0);
        check("mid_reset_data", o_data, 32'd0);
        check("mid_reset_ch", 32'(o_ch), 32'd0);
        rst = 1'b0; i_ready = 1'b1; i_rr_en = 1'b1; i_valid = 7'b0101000;
        cycle();
        check("post_reset_rr", 32'(o_ch), 32'd3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            i_rr_en = 1'($urandom_range(0, 1));
            i_sel   = SEL_W'($urandom_range(0, 15));
            i_valid = NUM_IN'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NUM_IN; k++) set_ch(k, $urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
